// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the control sequencer: opcode encodings, FSM
// states, instruction classes, ALUControl one-hot constants and IR field
// bit positions.
package cpu_ctrl_pkg;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_MSB  = 18;
  localparam int unsigned RC_LSB  = 15;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000,
    OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_NEG  = 5'b01001,
    OP_NOT  = 5'b01010,
    OP_ADDI = 5'b01100,
    OP_NOP  = 5'b11010,
    OP_HALT = 5'b11011
  } opcode_e;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU3, CL_UNARY, CL_IMM, CL_LD, CL_ST, CL_NOP, CL_HALT, CL_ILLEGAL
  } iclass_e;

  localparam logic [11:0] ALU_NONE = 12'h000;
  localparam logic [11:0] ALU_ADD  = 12'h001;
  localparam logic [11:0] ALU_SUB  = 12'h002;
  localparam logic [11:0] ALU_AND  = 12'h004;
  localparam logic [11:0] ALU_OR   = 12'h008;
  localparam logic [11:0] ALU_NEG  = 12'h400;
  localparam logic [11:0] ALU_NOT  = 12'h800;

endpackage

// File: rtl/instr_decode.sv
// Opcode decoder: classifies an opcode and supplies its ALUControl value.
//   opcode_i  : IR opcode field
//   iclass_o  : instruction class (ILLEGAL for undefined opcodes)
//   alu_sel_o : one-hot ALU select used by the execute states
module instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]  opcode_i,
  output iclass_e     iclass_o,
  output logic [11:0] alu_sel_o
);

  always_comb begin
    iclass_o  = CL_ILLEGAL;
    alu_sel_o = ALU_NONE;
    case (opcode_i)
      OP_LD:   begin iclass_o = CL_LD;    alu_sel_o = ALU_ADD; end
      OP_ST:   begin iclass_o = CL_ST;    alu_sel_o = ALU_ADD; end
      OP_ADD:  begin iclass_o = CL_ALU3;  alu_sel_o = ALU_ADD; end
      OP_SUB:  begin iclass_o = CL_ALU3;  alu_sel_o = ALU_SUB; end
      OP_AND:  begin iclass_o = CL_ALU3;  alu_sel_o = ALU_AND; end
      OP_OR:   begin iclass_o = CL_ALU3;  alu_sel_o = ALU_OR;  end
      OP_NEG:  begin iclass_o = CL_UNARY; alu_sel_o = ALU_NEG; end
      OP_NOT:  begin iclass_o = CL_UNARY; alu_sel_o = ALU_NOT; end
      OP_ADDI: begin iclass_o = CL_IMM;   alu_sel_o = ALU_ADD; end
      OP_NOP:  iclass_o = CL_NOP;
      OP_HALT: iclass_o = CL_HALT;
      default: iclass_o = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer for a simple register-file CPU datapath.
//   clk, clr_n  : clock, asynchronous active-low reset
//   start       : leaves IDLE; afterwards fetching runs until HALT or reset
//   ir          : instruction register (opcode in ir[31:27])
//   mem_rdy     : memory handshake, affects transitions only
//   strobes     : datapath control strobes, decoded from state and ir
//   ALUControl  : one-hot ALU select
//   halted      : in HALT; illegal : undefined opcode seen in T3
//   instr_count : retired-instruction counter (wraps)
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDRRead,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        BAout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Write,
  output logic [11:0] ALUControl,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_count
);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        retire;
  iclass_e     iclass;
  logic [11:0] alu_sel;

  // Register fields are consumed by the datapath, not the sequencer.
  logic unused_ir;
  assign unused_ir = ^ir[RA_MSB:0];

  instr_decode u_decode (
    .opcode_i  (ir[OPC_MSB:OPC_LSB]),
    .iclass_o  (iclass),
    .alu_sel_o (alu_sel)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRRead, IRin, Yin, Zin,
     Zlowout, Cout, BAout, Gra, Grb, Grc, Rin, Rout, Write} = '0;
    ALUControl = ALU_NONE;
    illegal    = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; MDRRead = 1'b1; MDRin = 1'b1;
        if (mem_rdy) state_d = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T4;
        case (iclass)
          CL_ALU3, CL_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_UNARY: begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUControl = alu_sel;
          end
          CL_LD, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_NOP:  begin retire = 1'b1; state_d = S_T0; end
          CL_HALT: state_d = S_HALT;
          default: begin illegal = 1'b1; state_d = S_T0; end
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (iclass)
          CL_ALU3: begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUControl = alu_sel;
          end
          CL_IMM, CL_LD, CL_ST: begin
            Cout = 1'b1; Zin = 1'b1; ALUControl = alu_sel;
          end
          CL_UNARY: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            retire = 1'b1; state_d = S_T0;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        state_d = S_T0;
        case (iclass)
          CL_ALU3, CL_IMM: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; retire = 1'b1;
          end
          CL_LD, CL_ST: begin
            Zlowout = 1'b1; MARin = 1'b1; state_d = S_T6;
          end
          default: ;
        endcase
      end
      S_T6: begin
        state_d = S_T0;
        case (iclass)
          CL_LD: begin
            MDRRead = 1'b1; MDRin = 1'b1;
            state_d = mem_rdy ? S_T7 : S_T6;
          end
          CL_ST: begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = S_T7;
          end
          default: ;
        endcase
      end
      S_T7: begin
        state_d = S_T0;
        case (iclass)
          CL_LD: begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; retire = 1'b1;
          end
          CL_ST: begin
            Write = 1'b1;
            if (mem_rdy) retire = 1'b1;
            else         state_d = S_T7;
          end
          default: ;
        endcase
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign count_d     = retire ? count_q + 16'd1 : count_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_rdy = 1'b1;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRRead, IRin, Yin, Zin;
  logic Zlowout, Cout, BAout, Gra, Grb, Grc, Rin, Rout, Write;
  logic [11:0] ALUControl;
  logic        halted, illegal;
  logic [15:0] instr_count;
  logic [18:0] strb;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [18:0] PCOUT = 19'h40000, PCIN = 19'h20000, INCPC = 19'h10000;
  localparam logic [18:0] MARIN = 19'h08000, MDRIN = 19'h04000, MDROUT = 19'h02000;
  localparam logic [18:0] MDRREAD = 19'h01000, IRIN = 19'h00800, YIN = 19'h00400;
  localparam logic [18:0] ZIN = 19'h00200, ZLOW = 19'h00100, COUT = 19'h00080;
  localparam logic [18:0] BAOUT = 19'h00040, GRA = 19'h00020, GRB = 19'h00010;
  localparam logic [18:0] GRC = 19'h00008, RIN = 19'h00004, ROUT = 19'h00002;
  localparam logic [18:0] WRITE = 19'h00001;
  localparam logic [18:0] F0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [18:0] F1 = ZLOW | PCIN | MDRREAD | MDRIN;
  localparam logic [18:0] F2 = MDROUT | IRIN;

  control_sequencer dut (
    .clk(clk), .clr_n(clr_n), .start(start), .ir(ir), .mem_rdy(mem_rdy),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .MDRRead(MDRRead), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Cout(Cout), .BAout(BAout), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .Write(Write), .ALUControl(ALUControl),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  assign strb = {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRRead, IRin, Yin, Zin,
                 Zlowout, Cout, BAout, Gra, Grb, Grc, Rin, Rout, Write};

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    clr_n = 1'b0; start = 1'b0; mem_rdy = 1'b1;
    step();
    clr_n = 1'b1;
    step();
  endtask

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (strb !== 19'h0) $display("FAIL rst_strb: got %h want 0", strb); else n_pass++;
    n_total++; if (ALUControl !== 12'h0) $display("FAIL rst_alu: got %h want 0", ALUControl); else n_pass++;
    n_total++; if ({halted, illegal} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {halted, illegal}); else n_pass++;
    n_total++; if (instr_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", instr_count); else n_pass++;
    step(); clr_n = 1'b1; step(3);
    n_total++; if (strb !== 19'h0) $display("FAIL idle_hold: got %h want 0", strb); else n_pass++;
  endtask

  task automatic test_neg();
    do_reset(); ir = 32'h4A920000; launch();
    n_total++; if (strb !== F0) $display("FAIL neg_t0: got %h want %h", strb, F0); else n_pass++;
    step();
    n_total++; if (strb !== F1) $display("FAIL neg_t1: got %h want %h", strb, F1); else n_pass++;
    step();
    n_total++; if (strb !== F2) $display("FAIL neg_t2: got %h want %h", strb, F2); else n_pass++;
    step();
    n_total++; if (strb !== (GRB | ROUT | ZIN)) $display("FAIL neg_t3: got %h want %h", strb, GRB | ROUT | ZIN); else n_pass++;
    n_total++; if (ALUControl !== 12'h400) $display("FAIL neg_alu: got %h want 400", ALUControl); else n_pass++;
    step();
    n_total++; if (strb !== (ZLOW | GRA | RIN)) $display("FAIL neg_t4: got %h want %h", strb, ZLOW | GRA | RIN); else n_pass++;
    n_total++; if (instr_count !== 16'd0) $display("FAIL neg_cnt_pre: got %0d want 0", instr_count); else n_pass++;
    step();
    n_total++; if (instr_count !== 16'd1) $display("FAIL neg_cnt: got %0d want 1", instr_count); else n_pass++;
    n_total++; if (strb !== F0) $display("FAIL neg_refetch: got %h want %h", strb, F0); else n_pass++;
  endtask

  task automatic test_add();
    do_reset(); ir = 32'h19908000; launch(); // cycle 1 = T0
    step(3);
    n_total++; if (strb !== (GRB | ROUT | YIN)) $display("FAIL add_t3: got %h want %h", strb, GRB | ROUT | YIN); else n_pass++;
    step();
    n_total++; if (strb !== (GRC | ROUT | ZIN)) $display("FAIL add_t4: got %h want %h", strb, GRC | ROUT | ZIN); else n_pass++;
    n_total++; if (ALUControl !== 12'h001) $display("FAIL add_alu: got %h want 001", ALUControl); else n_pass++;
    step();
    n_total++; if (strb !== (ZLOW | GRA | RIN)) $display("FAIL add_t5: got %h want %h", strb, ZLOW | GRA | RIN); else n_pass++;
    step(); // cycle 7
    n_total++; if (strb !== F0) $display("FAIL add_c7_t0: got %h want %h", strb, F0); else n_pass++;
    n_total++; if (instr_count !== 16'd1) $display("FAIL add_cnt: got %0d want 1", instr_count); else n_pass++;
  endtask

  task automatic test_imm_fetch_hold();
    do_reset(); ir = 32'h60000000; mem_rdy = 1'b0; launch();
    step();
    n_total++; if (strb !== F1) $display("FAIL hold_t1a: got %h want %h", strb, F1); else n_pass++;
    step();
    n_total++; if (strb !== F1) $display("FAIL hold_t1b: got %h want %h", strb, F1); else n_pass++;
    mem_rdy = 1'b1; step();
    n_total++; if (strb !== F2) $display("FAIL hold_t2: got %h want %h", strb, F2); else n_pass++;
    step(2);
    n_total++; if (strb !== (COUT | ZIN)) $display("FAIL imm_t4: got %h want %h", strb, COUT | ZIN); else n_pass++;
    n_total++; if (ALUControl !== 12'h001) $display("FAIL imm_alu: got %h want 001", ALUControl); else n_pass++;
    step(2);
    n_total++; if (instr_count !== 16'd1) $display("FAIL imm_cnt: got %0d want 1", instr_count); else n_pass++;
  endtask

  task automatic test_ld();
    do_reset(); ir = 32'h01100000; launch(); step(3);
    n_total++; if (strb !== (GRB | BAOUT | YIN)) $display("FAIL ld_t3: got %h want %h", strb, GRB | BAOUT | YIN); else n_pass++;
    step();
    n_total++; if (strb !== (COUT | ZIN) || ALUControl !== 12'h001) $display("FAIL ld_t4: got %h/%h want %h/001", strb, ALUControl, COUT | ZIN); else n_pass++;
    step();
    n_total++; if (strb !== (ZLOW | MARIN)) $display("FAIL ld_t5: got %h want %h", strb, ZLOW | MARIN); else n_pass++;
    mem_rdy = 1'b0; step();
    for (int i = 0; i < 4; i++) begin
      n_total++; if (strb !== (MDRREAD | MDRIN)) $display("FAIL ld_t6_%0d: got %h want %h", i, strb, MDRREAD | MDRIN); else n_pass++;
      if (i == 3) mem_rdy = 1'b1;
      step();
    end
    n_total++; if (strb !== (MDROUT | GRA | RIN)) $display("FAIL ld_t7: got %h want %h", strb, MDROUT | GRA | RIN); else n_pass++;
    n_total++; if (instr_count !== 16'd0) $display("FAIL ld_cnt_pre: got %0d want 0", instr_count); else n_pass++;
    step();
    n_total++; if (instr_count !== 16'd1 || strb !== F0) $display("FAIL ld_done: got %0d/%h want 1/%h", instr_count, strb, F0); else n_pass++;
  endtask

  task automatic test_st();
    do_reset(); ir = 32'h10000000; launch(); step(5);
    n_total++; if (strb !== (ZLOW | MARIN)) $display("FAIL st_t5: got %h want %h", strb, ZLOW | MARIN); else n_pass++;
    step();
    n_total++; if (strb !== (GRA | ROUT | MDRIN)) $display("FAIL st_t6: got %h want %h", strb, GRA | ROUT | MDRIN); else n_pass++;
    mem_rdy = 1'b0; step();
    n_total++; if (strb !== WRITE) $display("FAIL st_t7a: got %h want %h", strb, WRITE); else n_pass++;
    step();
    n_total++; if (strb !== WRITE || instr_count !== 16'd0) $display("FAIL st_t7b: got %h/%0d want %h/0", strb, instr_count, WRITE); else n_pass++;
    mem_rdy = 1'b1; step();
    n_total++; if (instr_count !== 16'd1 || strb !== F0) $display("FAIL st_done: got %0d/%h want 1/%h", instr_count, strb, F0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset(); ir = 32'h20000000; launch(); step(4);
    n_total++; if (ALUControl !== 12'h002) $display("FAIL b2b_sub: got %h want 002", ALUControl); else n_pass++;
    step(2); ir = 32'h28000000; step(4);
    n_total++; if (ALUControl !== 12'h004) $display("FAIL b2b_and: got %h want 004", ALUControl); else n_pass++;
    step(2); ir = 32'h30000000; step(4);
    n_total++; if (ALUControl !== 12'h008) $display("FAIL b2b_or: got %h want 008", ALUControl); else n_pass++;
    step(2);
    n_total++; if (instr_count !== 16'd3) $display("FAIL b2b_cnt3: got %0d want 3", instr_count); else n_pass++;
    ir = 32'h50000000; step(3);
    n_total++; if (ALUControl !== 12'h800 || strb !== (GRB | ROUT | ZIN)) $display("FAIL b2b_not: got %h/%h want 800/%h", ALUControl, strb, GRB | ROUT | ZIN); else n_pass++;
    step(2);
    n_total++; if (instr_count !== 16'd4) $display("FAIL b2b_cnt4: got %0d want 4", instr_count); else n_pass++;
  endtask

  task automatic test_halt();
    do_reset(); ir = 32'hD8000000; launch(); step(3);
    n_total++; if (strb !== 19'h0 || halted !== 1'b0) $display("FAIL halt_t3: got %h/%b want 0/0", strb, halted); else n_pass++;
    step();
    n_total++; if (halted !== 1'b1 || strb !== 19'h0) $display("FAIL halt_enter: got %b/%h want 1/0", halted, strb); else n_pass++;
    start = 1'b1; step(3); start = 1'b0; step();
    n_total++; if (halted !== 1'b1 || strb !== 19'h0) $display("FAIL halt_stay: got %b/%h want 1/0", halted, strb); else n_pass++;
    n_total++; if (instr_count !== 16'd0) $display("FAIL halt_cnt: got %0d want 0", instr_count); else n_pass++;
  endtask

  task automatic test_illegal();
    do_reset(); ir = 32'hF8000000; launch(); step(3);
    n_total++; if (illegal !== 1'b1 || strb !== 19'h0) $display("FAIL ill_t3: got %b/%h want 1/0", illegal, strb); else n_pass++;
    step();
    n_total++; if (illegal !== 1'b0 || strb !== F0) $display("FAIL ill_next: got %b/%h want 0/%h", illegal, strb, F0); else n_pass++;
    n_total++; if (instr_count !== 16'd0) $display("FAIL ill_cnt: got %0d want 0", instr_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(); ir = 32'hD0000000; launch(); step(3);
    n_total++; if (strb !== 19'h0) $display("FAIL nop_t3: got %h want 0", strb); else n_pass++;
    step();
    n_total++; if (instr_count !== 16'd1 || strb !== F0) $display("FAIL nop_done: got %0d/%h want 1/%h", instr_count, strb, F0); else n_pass++;
    ir = 32'h19908000; step(4);
    n_total++; if (ALUControl !== 12'h001) $display("FAIL mid_t4: got %h want 001", ALUControl); else n_pass++;
    clr_n = 1'b0; #2;
    n_total++; if (strb !== 19'h0 || ALUControl !== 12'h0) $display("FAIL mid_rst_out: got %h/%h want 0/0", strb, ALUControl); else n_pass++;
    n_total++; if (instr_count !== 16'd0 || halted !== 1'b0 || illegal !== 1'b0) $display("FAIL mid_rst_state: got %0d/%b/%b want 0/0/0", instr_count, halted, illegal); else n_pass++;
    step(); clr_n = 1'b1; step(2);
    n_total++; if (strb !== 19'h0) $display("FAIL mid_idle: got %h want 0", strb); else n_pass++;
    launch();
    n_total++; if (strb !== F0) $display("FAIL mid_restart: got %h want %h", strb, F0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_neg();
    test_add();
    test_imm_fetch_hold();
    test_ld();
    test_st();
    test_back_to_back();
    test_halt();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
